// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART blocks: receiver states, parity modes
// and the receive FIFO entry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Entry payload is sized for the widest frame; narrower frames are zero-extended.
    localparam int MAX_DATA_BITS = 9;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     frame_err;
        logic                     parity_err;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Receive-side consumer port: head-of-FIFO entry with a valid/ready handshake.
// An entry transfers on any rising clk edge where data_valid && data_ready; the
// master holds data_out/frame_err/parity_err stable while data_valid && !data_ready.
interface uart_rx_ovs_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_err;
    logic                 parity_err;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_out, frame_err, parity_err, data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out, frame_err, parity_err, data_valid,
        output data_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick every TICK_DIV clocks while
// enabled; clear restarts the phase so the first tick lands TICK_DIV clocks later.
module uart_baud_tick #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority voting, start-glitch
// rejection and a small valid/ready FIFO carrying per-frame error flags.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    uart_rx_ovs_if.master        rx_if,
    output logic                 overrun,
    output logic                 busy,
    output rx_state_t            dbg_state
);
    localparam int TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int M        = OVERSAMPLE / 2;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [SW-1:0] S_LO  = SW'(M - 1);
    localparam logic [SW-1:0] S_MID = SW'(M);
    localparam logic [SW-1:0] S_HI  = SW'(M + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    logic       rx_meta_q, rx_meta_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [2:0] sync_vld_q, sync_vld_d;
    logic       fall_edge;

    // sync_vld tracks which pipeline stages hold real line samples, so the
    // reset value of 1 cannot fake a falling edge on a line held low.
    always_comb begin
        rx_meta_d  = rx;
        rxs_d      = rx_meta_q;
        rxs_prev_d = rxs_q;
        sync_vld_d = {sync_vld_q[1:0], 1'b1};
    end

    assign fall_edge = sync_vld_q[2] && rxs_prev_q && !rxs_q;

    rx_state_t            state_q, state_d;
    logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_sh_q, data_sh_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                 tick, tick_clear, maj, decide, bit_end, commit;
    rx_entry_t            commit_entry;

    assign tick_clear = (state_q == ST_IDLE) && fall_edge;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (tick_clear),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    assign maj     = majority3(s0_q, s1_q, rxs_q);
    assign decide  = tick && (samp_cnt_q == S_HI);
    assign bit_end = tick && (samp_cnt_q == S_END);

    always_comb begin
        state_d      = state_q;
        samp_cnt_d   = samp_cnt_q;
        bit_idx_d    = bit_idx_q;
        data_sh_d    = data_sh_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        commit       = 1'b0;

        if (tick) begin
            samp_cnt_d = (samp_cnt_q == S_END) ? '0 : samp_cnt_q + SW'(1);
            if (samp_cnt_q == S_LO)  s0_d = rxs_q;
            if (samp_cnt_q == S_MID) s1_d = rxs_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_d      = ST_START;
                    samp_cnt_d   = '0;
                    bit_idx_d    = '0;
                    frame_err_d  = 1'b0;
                    parity_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (decide && maj) state_d = ST_IDLE;
                else if (bit_end)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (decide) data_sh_d = {maj, data_sh_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_idx_q == LAST_DATA) begin
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) parity_err_d = (^data_sh_q) ^ maj ^ (PARITY == PAR_ODD);
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (decide) begin
                    if (!maj) frame_err_d = 1'b1;
                    // Leave mid stop bit so the next start edge is caught early.
                    if (bit_idx_q == LAST_STOP) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (bit_end) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        commit_entry            = '0;
        commit_entry.data       = MAX_DATA_BITS'(data_sh_q);
        commit_entry.frame_err  = frame_err_q | ~maj;
        commit_entry.parity_err = parity_err_q;
    end

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        overrun_q, overrun_d;
    logic        fifo_empty, fifo_full, push, pop;
    rx_entry_t   mem_q [FIFO_DEPTH];
    rx_entry_t   head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop       = !fifo_empty && rx_if.data_ready;
        push      = commit && (!fifo_full || pop);
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        overrun_d = commit && fifo_full && !pop;
    end

    if (DATA_BITS < MAX_DATA_BITS) begin : g_pad
        logic pad_unused;
        assign pad_unused = |head.data[MAX_DATA_BITS-1:DATA_BITS];
    end

    assign rx_if.data_valid = !fifo_empty;
    assign rx_if.data_out   = fifo_empty ? '0 : head.data[DATA_BITS-1:0];
    assign rx_if.frame_err  = !fifo_empty && head.frame_err;
    assign rx_if.parity_err = !fifo_empty && head.parity_err;
    assign overrun          = overrun_q;
    assign busy             = (state_q != ST_IDLE);
    assign dbg_state        = state_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= commit_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            sync_vld_q   <= '0;
            state_q      <= ST_IDLE;
            samp_cnt_q   <= '0;
            bit_idx_q    <= '0;
            data_sh_q    <= '0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            sync_vld_q   <= sync_vld_d;
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_sh_q    <= data_sh_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overrun_q    <= overrun_d;
        end
    end
endmodule
